// File: rtl/tank_draw_pkg.sv
// Shared definitions for the tank sprite drawer: FSM state type, screen
// geometry defaults, colour type and the background (erase) colour.
package tank_draw_pkg;

  localparam int unsigned SCREEN_W_DEF    = 320;
  localparam int unsigned SCREEN_H_DEF    = 240;
  localparam int unsigned COLOUR_BITS_DEF = 3;

  typedef logic [COLOUR_BITS_DEF-1:0] colour_t;

  localparam colour_t BG_COLOUR_DEF = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StDraw,
    StDone
  } state_t;

endpackage

// File: rtl/sprite_mask_lookup.sv
// Combinational sprite shape lookup: (row, column, facing) -> opaque bit.
// Mask bit index is row*N + column of the (possibly rotated) coordinate.
// Optional feature macro: SPRITE_ROTATE_EN selects a rotated read index
// from dir; without it dir is ignored and the mask is read unrotated.
module sprite_mask_lookup #(
  parameter int unsigned        N    = 8,
  parameter int unsigned        CW   = 3,
  parameter logic [N*N-1:0]     MASK = '1
) (
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] c,
  input  logic [1:0]    dir,
  output logic          opaque
);

  localparam int unsigned IW = (N > 1) ? $clog2(N * N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] sr;
  logic [CW-1:0] sc;
  logic [IW-1:0] idx;

`ifdef SPRITE_ROTATE_EN
  // Map the scan coordinate onto the stored (north-facing) shape.
  always_comb begin
    sr = r;
    sc = c;
    unique case (dir)
      2'd0: begin sr = r;        sc = c;        end
      2'd1: begin sr = LAST - c; sc = r;        end
      2'd2: begin sr = LAST - r; sc = LAST - c; end
      2'd3: begin sr = c;        sc = LAST - r; end
    endcase
  end
`else
  logic unused_dir;
  logic [CW-1:0] unused_last;
  assign unused_dir  = ^dir;
  assign unused_last = LAST;
  assign sr = r;
  assign sc = c;
`endif

  assign idx    = IW'(sr) * IW'(N) + IW'(sc);
  assign opaque = MASK[idx];

endmodule

// File: rtl/tank_sprite_drawer.sv
// Tank sprite pixel-write sequencer feeding the VGA frame-buffer adapter.
// Per request: erase the sprite at its previous position with BG_COLOUR
// (skipped when no previous position exists), then draw it at the new one,
// emitting one registered (x, y, colour, plot) write per clock.
// Optional feature macro: SPRITE_ROTATE_EN (rotated mask read by facing).
module tank_sprite_drawer
  import tank_draw_pkg::*;
#(
  parameter int unsigned                        SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned                        SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned                        SPRITE_SIZE = 8,
  parameter logic [SPRITE_SIZE*SPRITE_SIZE-1:0] SPRITE_MASK = '1,
  parameter int unsigned                        COLOUR_BITS = COLOUR_BITS_DEF,
  parameter logic [COLOUR_BITS-1:0]             BG_COLOUR   = BG_COLOUR_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8:0]             new_x,
  input  logic [7:0]             new_y,
  input  logic [COLOUR_BITS-1:0] tank_colour,
  input  logic [1:0]             dir,
  output logic                   busy,
  output logic                   done,
  output logic [8:0]             x,
  output logic [7:0]             y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot
);

  localparam int unsigned CW = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPRITE_SIZE - 1);

  state_t                 state_q;
  logic [CW-1:0]          r_q;
  logic [CW-1:0]          c_q;
  logic [8:0]             new_x_q;
  logic [7:0]             new_y_q;
  logic [COLOUR_BITS-1:0] colour_q;
  logic [1:0]             dir_q;
  logic [8:0]             prev_x_q;
  logic [7:0]             prev_y_q;
  logic [1:0]             prev_dir_q;
  logic                   prev_valid_q;

  logic                   erasing;
  logic [8:0]             base_x;
  logic [7:0]             base_y;
  logic [1:0]             look_dir;
  logic [COLOUR_BITS-1:0] pix_colour;
  logic [9:0]             px;
  logic [9:0]             py;
  logic                   opaque;
  logic                   pix_plot;
  logic                   unused_msbs;

  sprite_mask_lookup #(
    .N    (SPRITE_SIZE),
    .CW   (CW),
    .MASK (SPRITE_MASK)
  ) u_mask (
    .r      (r_q),
    .c      (c_q),
    .dir    (look_dir),
    .opaque (opaque)
  );

  // Current pixel: ERASE works on the previous placement, DRAW on the new one.
  // Coordinates are 10 bits wide so an off-screen pixel never wraps on-screen.
  always_comb begin
    erasing    = (state_q == StErase);
    base_x     = erasing ? prev_x_q : new_x_q;
    base_y     = erasing ? prev_y_q : new_y_q;
    look_dir   = erasing ? prev_dir_q : dir_q;
    pix_colour = erasing ? BG_COLOUR : colour_q;
    px         = {1'b0, base_x} + 10'(c_q);
    py         = {2'b00, base_y} + 10'(r_q);
    pix_plot   = opaque && (px < 10'(SCREEN_W)) && (py < 10'(SCREEN_H));
  end

  // Clipped pixels never reach the outputs, so the top bits are not needed there.
  assign unused_msbs = ^{px[9], py[9:8]};

  // Sequencer FSM with registered pixel outputs (one cycle behind the counters).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      r_q          <= '0;
      c_q          <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      colour_q     <= '0;
      dir_q        <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_dir_q   <= '0;
      prev_valid_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      plot         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          plot <= 1'b0;
          if (start) begin
            new_x_q  <= new_x;
            new_y_q  <= new_y;
            colour_q <= tank_colour;
            dir_q    <= dir;
            r_q      <= '0;
            c_q      <= '0;
            busy     <= 1'b1;
            state_q  <= prev_valid_q ? StErase : StDraw;
          end
        end
        StErase, StDraw: begin
          x      <= px[8:0];
          y      <= py[7:0];
          colour <= pix_colour;
          plot   <= pix_plot;
          if (c_q == LAST) begin
            c_q <= '0;
            if (r_q == LAST) begin
              r_q <= '0;
              if (state_q == StErase) begin
                state_q <= StDraw;
              end else begin
                state_q      <= StDone;
                done         <= 1'b1;
                prev_x_q     <= new_x_q;
                prev_y_q     <= new_y_q;
                prev_dir_q   <= dir_q;
                prev_valid_q <= 1'b1;
              end
            end else begin
              r_q <= r_q + 1'b1;
            end
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        StDone: begin
          // Outputs still hold the last DRAW pixel during this cycle.
          busy    <= 1'b0;
          plot    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
